hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised load-use hazard unit for the 5-stage pipeline, between IF/ID and ID/EX.
//  Detects RAW hazards on in-flight loads with configurable load-to-use latency.
//  Tracks long loads in a per-register pending scoreboard.
//  Resolves memory wait, taken-branch flush and stall/flush priority.
//  Keeps saturating stall and flush performance counters.
//  With LOAD_LAT=0 it reduces to the single-cycle ID/EX load-use compare.
// PARAMETERS
//  AW        5   register address width; NREGS = 2**AW
//  LOAD_LAT  1   extra cycles after MEM before load data can be forwarded (0..7)
//  CNT_W     16  width of each performance counter
//  X0_HARD   1   1: register 0 never causes a hazard
// PORTS
//  CLK             in   1      rising-edge clock
//  RST_N           in   1      asynchronous active-low reset
//  MEMREAD_ID_EX   in   1      instruction in ID/EX is a load
//  ARD_ID_EX       in   AW     destination register of the ID/EX instruction
//  ARS1_IF_ID      in   AW     source 1 of the IF/ID instruction
//  ARS2_IF_ID      in   AW     source 2 of the IF/ID instruction
//  USE_RS1_IF_ID   in   1      IF/ID instruction reads rs1
//  USE_RS2_IF_ID   in   1      IF/ID instruction reads rs2
//  MEM_READY       in   1      data memory done this cycle; 0 = wait state
//  BRANCH_TAKEN_EX in   1      branch/jump in EX is taken
//  STALL           out  1      hold PC and IF/ID
//  MUX_SEL         out  1      inject bubble (zero control) into ID/EX
//  FREEZE          out  1      hold all pipeline registers (memory wait)
//  FLUSH_IF_ID     out  1      squash IF/ID
//  FLUSH_ID_EX     out  1      squash ID/EX
//  STALL_CNT       out  CNT_W  bubbles inserted, saturating
//  FLUSH_CNT       out  CNT_W  taken-branch flushes, saturating
// BEHAVIOUR
//  Reset (RST_N=0, async): all pend[] = 0; STALL_CNT and FLUSH_CNT = 0.
//    Outputs are combinational from state, so all control outputs = 0 while reset is held
//    and inputs are idle.
//  Source match:
//    match_k = USE_RSk_IF_ID && ARSk_IF_ID == X && !(X0_HARD && X == 0).
//  Hazard: haz = (MEMREAD_ID_EX && match(ARD_ID_EX)) || (pend[ARS1] != 0 && match_1)
//    || (pend[ARS2] != 0 && match_2).
//  Output priority, combinational, same cycle, highest first:
//    1. MEM_READY=0: FREEZE=1, STALL=1, MUX_SEL=0, flushes=0.
//       pend[] and counters hold.
//    2. BRANCH_TAKEN_EX=1: FLUSH_IF_ID=1, FLUSH_ID_EX=1, STALL=0, MUX_SEL=0.
//       FLUSH_CNT +1. A hazard on the squashed instruction is ignored.
//    3. haz=1: STALL=1, MUX_SEL=1; STALL_CNT +1.
//    4. Otherwise all control outputs = 0.
//  Scoreboard update, on clock edge when MEM_READY=1:
//    - Every nonzero pend[r] decrements by 1.
//    - If MEMREAD_ID_EX=1, LOAD_LAT>0, the ID/EX entry is not squashed (BRANCH_TAKEN_EX=0)
//      and ARD_ID_EX is not hardwired 0: pend[ARD_ID_EX] <= LOAD_LAT.
//      This load write beats the decrement on the same register.
//    - A bubble (MUX_SEL=1) does not block the load in ID/EX; it still advances and is
//      scored.
//  Counters saturate at 2**CNT_W-1; they never wrap.
//  Reset mid-stall clears pend[] immediately; the next cycle sees no hazard.
// STRUCTURE
//  Package hazard_pkg: AW, typedef reg_addr_t, typedef lat_t (3 bits), enum ctl_prio_e
//    (PRIO_FREEZE, PRIO_FLUSH, PRIO_STALL, PRIO_NONE).
//  Sub-module hazard_pend_ctr: one lat_t down-counter with load, decrement and hold.
//    Instantiated NREGS times by generate.
//  Top level: compare logic, priority mux, two saturating counters.
// TESTING
//  1. LOAD_LAT=0; MEMREAD=1, ARD=1, ARS1=1, USE_RS1=1 -> STALL=1, MUX_SEL=1 for 1 cycle;
//     ARD=3 -> STALL=0.
//  2. LOAD_LAT=2; load to x5, then an instruction using x5 in IF/ID for 3 cycles ->
//     STALL high for 3 cycles total, then 0. STALL_CNT = 3.
//  3. Same as 2 with MEM_READY=0 for 2 cycles mid-countdown -> FREEZE=1, MUX_SEL=0
//     during the wait. Stall is extended by exactly 2 cycles.
//  4. Hazard on x2 with BRANCH_TAKEN_EX=1 in the same cycle -> both flushes = 1,
//     STALL=0, FLUSH_CNT = 1, STALL_CNT unchanged.
//  5. X0_HARD=1; load to x0 with ARS1=0 -> no stall; pend[0] stays 0.
//     USE_RS2=0 with ARS2 matching -> no stall.
//  6. CNT_W=2; 5 consecutive bubbles -> STALL_CNT = 3. Assert RST_N low mid-stall ->
//     counters and pend[] = 0 and STALL = 0 once inputs are idle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the load-use hazard scoreboard: register address,
// load-latency counter type and the control priority encoding.
package hazard_pkg;

    localparam int AW    = 5;
    localparam int LAT_W = 3;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [LAT_W-1:0] lat_t;

    // Control outcome for one cycle, listed highest priority first.
    typedef enum logic [1:0] {
        PRIO_FREEZE,
        PRIO_FLUSH,
        PRIO_STALL,
        PRIO_NONE
    } ctl_prio_e;

    // Decrement that stops at zero; an idle entry stays idle.
    function automatic lat_t lat_dec(input lat_t v);
        return (v == '0) ? v : v - lat_t'(1);
    endfunction

endpackage

// File: rtl/hazard_pend_ctr.sv
// One scoreboard entry: cycles remaining until a long load's data can be
// forwarded to a consumer. Load wins over decrement; nothing moves while the
// pipeline is frozen on a memory wait.
module hazard_pend_ctr
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  lat_t load_val_i,
    input  logic dec_i,
    output logic busy_o
);

    lat_t cnt_q, cnt_d;

    // Next count: new load, else step down towards zero, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = lat_dec(cnt_q);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard unit between IF/ID and ID/EX. Combines the classic ID/EX
// load compare with a per-register pending scoreboard for loads whose data
// arrives LOAD_LAT cycles after MEM, then resolves memory wait, taken-branch
// flush and load-use stall in that priority order. Stall and flush events are
// counted in saturating performance counters.
module hazard_scoreboard_unit #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,     // 0..7; 0 disables the scoreboard
    parameter int CNT_W    = 16,
    parameter bit X0_HARD  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memread_id_ex_i,
    input  logic [AW-1:0]    ard_id_ex_i,
    input  logic [AW-1:0]    ars1_if_id_i,
    input  logic [AW-1:0]    ars2_if_id_i,
    input  logic             use_rs1_if_id_i,
    input  logic             use_rs2_if_id_i,
    input  logic             mem_ready_i,
    input  logic             branch_taken_ex_i,
    output logic             stall_o,
    output logic             mux_sel_o,
    output logic             freeze_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    import hazard_pkg::*;

    localparam int   NREGS    = 2**AW;
    localparam lat_t LOAD_VAL = lat_t'(LOAD_LAT);

    // A source only matters if the instruction reads it and it is not x0.
    function automatic logic src_match(input logic          use_src,
                                       input logic [AW-1:0] src,
                                       input logic [AW-1:0] x);
        return use_src && (src == x) && !(X0_HARD && (x == '0));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic [NREGS-1:0] pend_busy;
    logic             sb_load;
    logic             haz_idex;
    logic             haz_pend1;
    logic             haz_pend2;
    logic             haz;
    ctl_prio_e        prio;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A load in ID/EX is scored whenever the pipeline advances and it is not
    // being squashed; a bubble injected behind it does not hold it back.
    assign sb_load = mem_ready_i && memread_id_ex_i && (LOAD_LAT != 0)
                     && !branch_taken_ex_i;

    for (genvar r = 0; r < NREGS; r++) begin : g_pend
        logic load_r;

        assign load_r = sb_load && (ard_id_ex_i == AW'(r))
                        && !(X0_HARD && (r == 0));

        hazard_pend_ctr u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (load_r),
            .load_val_i (LOAD_VAL),
            .dec_i      (mem_ready_i),
            .busy_o     (pend_busy[r])
        );
    end

    // Hazard sources: load directly ahead in ID/EX, or a still-pending long load.
    always_comb begin
        haz_idex  = memread_id_ex_i
                    && (src_match(use_rs1_if_id_i, ars1_if_id_i, ard_id_ex_i)
                        || src_match(use_rs2_if_id_i, ars2_if_id_i, ard_id_ex_i));
        haz_pend1 = pend_busy[ars1_if_id_i]
                    && src_match(use_rs1_if_id_i, ars1_if_id_i, ars1_if_id_i);
        haz_pend2 = pend_busy[ars2_if_id_i]
                    && src_match(use_rs2_if_id_i, ars2_if_id_i, ars2_if_id_i);
        haz       = haz_idex || haz_pend1 || haz_pend2;
    end

    // Priority resolution: memory wait, then branch flush, then load-use stall.
    always_comb begin
        prio = PRIO_NONE;
        if (!mem_ready_i) begin
            prio = PRIO_FREEZE;
        end else if (branch_taken_ex_i) begin
            prio = PRIO_FLUSH;
        end else if (haz) begin
            prio = PRIO_STALL;
        end
    end

    // Decode the winning priority into the pipeline control lines.
    always_comb begin
        stall_o       = 1'b0;
        mux_sel_o     = 1'b0;
        freeze_o      = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        case (prio)
            PRIO_FREEZE: begin
                freeze_o = 1'b1;
                stall_o  = 1'b1;
            end
            PRIO_FLUSH: begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end
            PRIO_STALL: begin
                stall_o   = 1'b1;
                mux_sel_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter next state: count bubbles and flushes, never during a freeze.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (prio == PRIO_STALL) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (prio == PRIO_FLUSH) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit. Three instances share one set of
// inputs: LOAD_LAT=0, LOAD_LAT=2, and LOAD_LAT=1 with 2-bit counters.
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       memread;
    logic [4:0] ard, ars1, ars2;
    logic       use1, use2, mem_ready, branch;

    logic a_stall, a_mux, a_frz, a_fif, a_fex;
    logic b_stall, b_mux, b_frz, b_fif, b_fex;
    logic c_stall, c_mux, c_frz, c_fif, c_fex;
    logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
    logic [1:0]  c_scnt, c_fcnt;
    logic [4:0]  a_ctl, b_ctl, c_ctl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Control vectors: {STALL, MUX_SEL, FREEZE, FLUSH_IF_ID, FLUSH_ID_EX}
    assign a_ctl = {a_stall, a_mux, a_frz, a_fif, a_fex};
    assign b_ctl = {b_stall, b_mux, b_frz, b_fif, b_fex};
    assign c_ctl = {c_stall, c_mux, c_frz, c_fif, c_fex};

    hazard_scoreboard_unit #(.AW(5), .LOAD_LAT(0), .CNT_W(16), .X0_HARD(1'b1)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .memread_id_ex_i(memread), .ard_id_ex_i(ard),
        .ars1_if_id_i(ars1), .ars2_if_id_i(ars2), .use_rs1_if_id_i(use1),
        .use_rs2_if_id_i(use2), .mem_ready_i(mem_ready), .branch_taken_ex_i(branch),
        .stall_o(a_stall), .mux_sel_o(a_mux), .freeze_o(a_frz), .flush_if_id_o(a_fif),
        .flush_id_ex_o(a_fex), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt));

    hazard_scoreboard_unit #(.AW(5), .LOAD_LAT(2), .CNT_W(16), .X0_HARD(1'b1)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .memread_id_ex_i(memread), .ard_id_ex_i(ard),
        .ars1_if_id_i(ars1), .ars2_if_id_i(ars2), .use_rs1_if_id_i(use1),
        .use_rs2_if_id_i(use2), .mem_ready_i(mem_ready), .branch_taken_ex_i(branch),
        .stall_o(b_stall), .mux_sel_o(b_mux), .freeze_o(b_frz), .flush_if_id_o(b_fif),
        .flush_id_ex_o(b_fex), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt));

    hazard_scoreboard_unit #(.AW(5), .LOAD_LAT(1), .CNT_W(2), .X0_HARD(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .memread_id_ex_i(memread), .ard_id_ex_i(ard),
        .ars1_if_id_i(ars1), .ars2_if_id_i(ars2), .use_rs1_if_id_i(use1),
        .use_rs2_if_id_i(use2), .mem_ready_i(mem_ready), .branch_taken_ex_i(branch),
        .stall_o(c_stall), .mux_sel_o(c_mux), .freeze_o(c_frz), .flush_if_id_o(c_fif),
        .flush_id_ex_o(c_fex), .stall_cnt_o(c_scnt), .flush_cnt_o(c_fcnt));

    task automatic set_idle();
        memread = 1'b0; ard = '0; ars1 = '0; ars2 = '0;
        use1 = 1'b0; use2 = 1'b0; mem_ready = 1'b1; branch = 1'b0;
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({a_ctl, b_ctl, c_ctl} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b/%b/%b want 00000 each", a_ctl, b_ctl, c_ctl);
        end
        n_cmp++;
        if ({a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt} !== 68'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d %0d %0d %0d %0d %0d want all 0",
                     a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_lat0();
        do_reset();
        memread = 1'b1; ard = 5'd1; ars1 = 5'd1; use1 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_ctl !== 5'b11000) begin
            n_bad++;
            $display("FAIL lat0_rs1_hit: got %b want %b", a_ctl, 5'b11000);
        end
        next_cycle();
        memread = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL lat0_after_bubble: got %b want %b", a_ctl, 5'b00000);
        end
        next_cycle();
        memread = 1'b1; ard = 5'd3;
        @(negedge clk);
        n_cmp++;
        if (a_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL lat0_ard_miss: got %b want %b", a_ctl, 5'b00000);
        end
        ars2 = 5'd3; use2 = 1'b1;
        #1;
        n_cmp++;
        if (a_ctl !== 5'b11000) begin
            n_bad++;
            $display("FAIL lat0_rs2_hit: got %b want %b", a_ctl, 5'b11000);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_lat2();
        int stalls;
        stalls = 0;
        do_reset();
        memread = 1'b1; ard = 5'd5; ars1 = 5'd5; use1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b_stall === 1'b1) stalls++;
            n_cmp++;
            if (b_ctl !== ((i < 3) ? 5'b11000 : 5'b00000)) begin
                n_bad++;
                $display("FAIL lat2_cycle%0d: got %b want %b", i, b_ctl,
                         (i < 3) ? 5'b11000 : 5'b00000);
            end
            next_cycle();
            memread = 1'b0;
        end
        n_cmp++;
        if (stalls != 3) begin
            n_bad++;
            $display("FAIL lat2_stall_cycles: got %0d want 3", stalls);
        end
        n_cmp++;
        if (b_scnt !== 16'd3) begin
            n_bad++;
            $display("FAIL lat2_stall_cnt: got %0d want 3", b_scnt);
        end
        set_idle();
    endtask

    task automatic test_mem_wait();
        logic       rdy [7];
        logic [4:0] exp [7];
        int stalls;
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp = '{5'b11000, 5'b11000, 5'b10100, 5'b10100, 5'b11000, 5'b00000, 5'b00000};
        stalls = 0;
        do_reset();
        memread = 1'b1; ard = 5'd5; ars1 = 5'd5; use1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            if (b_stall === 1'b1) stalls++;
            n_cmp++;
            if (b_ctl !== exp[i]) begin
                n_bad++;
                $display("FAIL memwait_cycle%0d: got %b want %b", i, b_ctl, exp[i]);
            end
            next_cycle();
            memread = 1'b0;
        end
        n_cmp++;
        if (stalls != 5) begin
            n_bad++;
            $display("FAIL memwait_stall_cycles: got %0d want 5", stalls);
        end
        n_cmp++;
        if (b_scnt !== 16'd3) begin
            n_bad++;
            $display("FAIL memwait_stall_cnt: got %0d want 3", b_scnt);
        end
        set_idle();
    endtask

    task automatic test_branch_priority();
        do_reset();
        memread = 1'b1; ard = 5'd2; ars1 = 5'd2; use1 = 1'b1; branch = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_ctl !== 5'b00011) begin
            n_bad++;
            $display("FAIL branch_flush: got %b want %b", b_ctl, 5'b00011);
        end
        next_cycle();
        memread = 1'b0; branch = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL branch_squashed_load: got %b want %b", b_ctl, 5'b00000);
        end
        n_cmp++;
        if (b_fcnt !== 16'd1 || b_scnt !== 16'd0) begin
            n_bad++;
            $display("FAIL branch_counts: got flush=%0d stall=%0d want flush=1 stall=0",
                     b_fcnt, b_scnt);
        end
        next_cycle();
        mem_ready = 1'b0; branch = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_ctl !== 5'b10100) begin
            n_bad++;
            $display("FAIL freeze_over_branch: got %b want %b", b_ctl, 5'b10100);
        end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++;
        if (b_fcnt !== 16'd1) begin
            n_bad++;
            $display("FAIL freeze_no_flush_count: got %0d want 1", b_fcnt);
        end
        next_cycle();
    endtask

    task automatic test_x0_and_use();
        do_reset();
        memread = 1'b1; ard = 5'd0; ars1 = 5'd0; use1 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL x0_load: got %b want %b", b_ctl, 5'b00000);
        end
        next_cycle();
        memread = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL x0_after_load: got %b want %b", b_ctl, 5'b00000);
        end
        next_cycle();
        memread = 1'b1; ard = 5'd4; ars1 = 5'd7; ars2 = 5'd4; use1 = 1'b1; use2 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL rs2_unused: got %b want %b", b_ctl, 5'b00000);
        end
        use2 = 1'b1;
        #1;
        n_cmp++;
        if (b_ctl !== 5'b11000) begin
            n_bad++;
            $display("FAIL rs2_used: got %b want %b", b_ctl, 5'b11000);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        memread = 1'b1; ard = 5'd1; ars1 = 5'd1; use1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (c_stall !== 1'b1 || c_scnt !== 2'((i < 3) ? i : 3)) begin
                n_bad++;
                $display("FAIL sat_bubble%0d: got stall=%b cnt=%0d want stall=1 cnt=%0d",
                         i, c_stall, c_scnt, (i < 3) ? i : 3);
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (c_scnt !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_no_wrap: got %0d want 3", c_scnt);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (c_scnt !== 2'd0 || c_fcnt !== 2'd0) begin
            n_bad++;
            $display("FAIL midstall_reset_cnt: got %0d/%0d want 0/0", c_scnt, c_fcnt);
        end
        set_idle();
        #1;
        n_cmp++;
        if (c_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL midstall_reset_ctl: got %b want %b", c_ctl, 5'b00000);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        ars1 = 5'd1; use1 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (c_ctl !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_clears_pend: got %b want %b", c_ctl, 5'b00000);
        end
        next_cycle();
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b1;
        test_reset();
        test_lat0();
        test_lat2();
        test_mem_wait();
        test_branch_priority();
        test_x0_and_use();
        test_saturation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
